// File: rtl/dmem_bus_if_pkg.sv
// dmem_bus_if_pkg -- shared definitions for the data-memory bus interface.
//   state_t             : bus FSM state encoding (IDLE, BUSY, HOLD)
//   SZ_BYTE/HALF/WORD   : mem_size codes (2'b11 is reserved and handled as word)
//   STALL_EX/STALL_MEM  : bit indices into the pipeline stall vector
//   misaligned()        : natural-alignment test for a size/address pair
package dmem_bus_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return (lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align -- big-endian byte-lane steering (purely combinational).
//   addr_lo   in  2  : low address bits; bits below the natural alignment are ignored
//   size      in  2  : SZ_BYTE / SZ_HALF / SZ_WORD (2'b11 handled as word)
//   sext      in  1  : sign-extend the extracted byte/half
//   wdata     in  32 : right-justified store data
//   bus_rdata in  32 : raw bus read word
//   sel       out 4  : byte lane enables, sel[3] = bits [31:24]
//   wdata_rep out 32 : store data replicated over all lanes
//   rdata_ext out 32 : extracted and extended load data
module dmem_lane_align
    import dmem_bus_if_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        case (addr_lo)
            2'b00:   rd_byte = bus_rdata[31:24];
            2'b01:   rd_byte = bus_rdata[23:16];
            2'b10:   rd_byte = bus_rdata[15:8];
            default: rd_byte = bus_rdata[7:0];
        endcase
        rd_half = addr_lo[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    end

    always_comb begin
        sel       = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = bus_rdata;
        case (size)
            SZ_BYTE: begin
                sel       = 4'b1000 >> addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sext & rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sext & rd_half[15]}}, rd_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_bus_if.sv
// dmem_bus_if -- MEM-stage load/store to single-outstanding bus master bridge.
// Optional feature: define DMEM_ADDR_CHECK_EN to flag misaligned accesses on
// adel/ades instead of silently truncating them to natural alignment.
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   stall[5:0]          : pipeline stall vector ([3] EX held, [4] MEM/WB held)
//   flush               : abort the pending access
//   mem_req/we/addr/wdata/size/sext : access request from the MEM stage
//   mem_rdata           : aligned, extended load result (0 outside an access)
//   stallreq            : freeze request to the pipeline
//   bus_*_o / bus_*_i   : bus master signals (word-aligned address, lane selects)
//   adel / ades         : load / store address error
module dmem_bus_if
    import dmem_bus_if_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_size,
    input  logic        mem_sext,
    output logic [31:0] mem_rdata,
    output logic        stallreq,
    output logic [31:0] bus_adr_o,
    output logic [31:0] bus_dat_o,
    output logic [3:0]  bus_sel_o,
    output logic        bus_we_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    output logic        adel,
    output logic        ades
);

    state_t      state, state_nxt;
    logic        armed;      // a fresh instruction has entered MEM since the last start
    logic        flushed;    // current bus cycle was aborted; its data is dropped
    logic [1:0]  lat_lo, lat_size;
    logic        lat_sext;
    logic [31:0] hold_buf;
    logic        addr_err, start, ack_ok;

    logic [1:0]  ln_lo, ln_size;
    logic        ln_sext;
    logic [3:0]  ln_sel;
    logic [31:0] ln_wdata, ln_rdata;

    // Only the EX and MEM bits of the stall vector matter here.
    logic        unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

`ifdef DMEM_ADDR_CHECK_EN
    assign addr_err = mem_req & misaligned(mem_size, mem_addr[1:0]);
    assign adel     = addr_err & ~mem_we;
    assign ades     = addr_err & mem_we;
`else
    assign addr_err = 1'b0;
    assign adel     = 1'b0;
    assign ades     = 1'b0;
`endif

    // In IDLE the lane logic steers the incoming request; once the bus cycle
    // is running it extracts read data using the attributes latched at start.
    always_comb begin
        ln_lo   = lat_lo;
        ln_size = lat_size;
        ln_sext = lat_sext;
        if (state == IDLE) begin
            ln_lo   = mem_addr[1:0];
            ln_size = mem_size;
            ln_sext = mem_sext;
        end
    end

    dmem_lane_align u_lane (
        .addr_lo   (ln_lo),
        .size      (ln_size),
        .sext      (ln_sext),
        .wdata     (mem_wdata),
        .bus_rdata (bus_dat_i),
        .sel       (ln_sel),
        .wdata_rep (ln_wdata),
        .rdata_ext (ln_rdata)
    );

    assign start  = (state == IDLE) & mem_req & ~flush & ~addr_err & armed & ~rst;
    assign ack_ok = bus_ack_i & ~flush & ~flushed;

    always_comb begin
        state_nxt = state;
        stallreq  = 1'b0;
        mem_rdata = 32'h0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = BUSY;
                    stallreq  = 1'b1;
                end
            end
            BUSY: begin
                if (bus_ack_i) begin
                    mem_rdata = ack_ok ? ln_rdata : 32'h0;
                    state_nxt = (ack_ok && stall[STALL_MEM]) ? HOLD : IDLE;
                end else begin
                    stallreq = ~flush & ~flushed;
                end
            end
            HOLD: begin
                mem_rdata = hold_buf;
                if (flush || !stall[STALL_MEM])
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            armed     <= 1'b1;
            flushed   <= 1'b0;
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            bus_we_o  <= 1'b0;
            bus_sel_o <= 4'h0;
            bus_adr_o <= 32'h0;
            bus_dat_o <= 32'h0;
            hold_buf  <= 32'h0;
            lat_lo    <= 2'b00;
            lat_size  <= SZ_WORD;
            lat_sext  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (start)
                armed <= 1'b0;
            else if (!stall[STALL_EX])
                armed <= 1'b1;

            if (start) begin
                bus_cyc_o <= 1'b1;
                bus_stb_o <= 1'b1;
                bus_we_o  <= mem_we;
                bus_sel_o <= ln_sel;
                bus_adr_o <= {mem_addr[31:2], 2'b00};
                bus_dat_o <= ln_wdata;
                lat_lo    <= mem_addr[1:0];
                lat_size  <= mem_size;
                lat_sext  <= mem_sext;
                flushed   <= 1'b0;
            end

            if (state == BUSY) begin
                if (flush)
                    flushed <= 1'b1;
                if (bus_ack_i) begin
                    bus_cyc_o <= 1'b0;
                    bus_stb_o <= 1'b0;
                    flushed   <= 1'b0;
                    if (ack_ok)
                        hold_buf <= ln_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Self-checking bench for dmem_bus_if: table of single accesses with a
// scoreboard of expected read data, plus hand-written HOLD / flush / reset /
// held-request / address-check sequences.
module tb_dmem_bus_if;
    import dmem_bus_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = 6'h0;
    logic        flush = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [1:0]  mem_size = SZ_WORD;
    logic        mem_sext = 1'b0;
    logic [31:0] mem_rdata;
    logic        stallreq;
    logic [31:0] bus_adr_o, bus_dat_o;
    logic [3:0]  bus_sel_o;
    logic        bus_we_o, bus_cyc_o, bus_stb_o;
    logic [31:0] bus_dat_i = 32'h0;
    logic        bus_ack_i = 1'b0;
    logic        adel, ades;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_bus_if dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_sext(mem_sext),
        .mem_rdata(mem_rdata), .stallreq(stallreq),
        .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o), .bus_sel_o(bus_sel_o),
        .bus_we_o(bus_we_o), .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o),
        .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i),
        .adel(adel), .ades(ades)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] wdata;
        logic [31:0] bdat;
        int          waits;
        logic [3:0]  esel;
        logic [31:0] edat_o;
        logic [31:0] erdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [3:0]  sel;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are read 1ns or more later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   sc;
        mem_req   = 1'b1;
        mem_we    = v.we;
        mem_addr  = v.addr;
        mem_size  = v.size;
        mem_sext  = v.sext;
        mem_wdata = v.wdata;
        sb.push_back('{v.erdata, v.esel});
        #1;
        sc = stallreq ? 1 : 0;
        tick();
        chk("cyc_start", bus_cyc_o, 1);
        chk("stb_start", bus_stb_o, 1);
        chk("adr", bus_adr_o, v.addr & 32'hFFFF_FFFC);
        chk("we", bus_we_o, v.we);
        if (v.we) chk("dat_o", bus_dat_o, v.edat_o);
        for (int i = 0; i < v.waits; i++) begin
            if (stallreq) sc++;
            tick();
        end
        chk("sel_held", bus_sel_o, v.esel);
        bus_ack_i = 1'b1;
        bus_dat_i = v.bdat;
        #1;
        chk("stallreq_ack", stallreq, 0);
        chk("stall_cycles", sc, v.waits + 1);
        e = sb.pop_front();
        chk("rdata_ack", mem_rdata, e.rdata);
        chk("sel", bus_sel_o, e.sel);
        tick();
        bus_ack_i = 1'b0;
        bus_dat_i = 32'hDEAD_DEAD;
        mem_req   = 1'b0;
        #1;
        chk("cyc_end", bus_cyc_o, 0);
        chk("rdata_idle", mem_rdata, 0);
    endtask

    initial begin
        //          we    addr          size     sx    wdata         bdat          w  sel      dat_o         rdata
        vecs.push_back('{1'b0, 32'h0000_0100, SZ_WORD, 1'b0, 32'h0,        32'h1122_3344, 3, 4'b1111, 32'h0,        32'h1122_3344});
        vecs.push_back('{1'b0, 32'h0000_0103, SZ_BYTE, 1'b1, 32'h0,        32'h0000_00F0, 1, 4'b0001, 32'h0,        32'hFFFF_FFF0});
        vecs.push_back('{1'b0, 32'h0000_0103, SZ_BYTE, 1'b0, 32'h0,        32'h0000_00F0, 0, 4'b0001, 32'h0,        32'h0000_00F0});
        vecs.push_back('{1'b1, 32'h0000_0202, SZ_HALF, 1'b0, 32'h0000_BEEF, 32'h0,        2, 4'b0011, 32'hBEEF_BEEF, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0101, SZ_BYTE, 1'b1, 32'h0,        32'h1280_5634, 0, 4'b0100, 32'h0,        32'hFFFF_FF80});
        vecs.push_back('{1'b0, 32'h0000_0200, SZ_HALF, 1'b1, 32'h0,        32'h8001_7FFF, 1, 4'b1100, 32'h0,        32'hFFFF_8001});
        vecs.push_back('{1'b0, 32'h0000_0202, SZ_HALF, 1'b0, 32'h0,        32'h8001_7FFF, 0, 4'b0011, 32'h0,        32'h0000_7FFF});
        vecs.push_back('{1'b1, 32'h0000_0302, SZ_BYTE, 1'b0, 32'h1234_56A5, 32'h0,        1, 4'b0010, 32'hA5A5_A5A5, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0404, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 32'h0,        0, 4'b1111, 32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_01FC, 2'b11,   1'b1, 32'h0,        32'h0A0B_0C0D, 1, 4'b1111, 32'h0,        32'h0A0B_0C0D});
`ifndef DMEM_ADDR_CHECK_EN
        vecs.push_back('{1'b0, 32'h0000_0102, SZ_WORD, 1'b0, 32'h0,        32'h5566_7788, 0, 4'b1111, 32'h0,        32'h5566_7788});
        vecs.push_back('{1'b0, 32'h0000_0203, SZ_HALF, 1'b1, 32'h0,        32'h1234_9ABC, 0, 4'b0011, 32'h0,        32'hFFFF_9ABC});
`endif

        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk("rst_cyc", bus_cyc_o, 0);
        chk("rst_stb", bus_stb_o, 0);
        chk("rst_we", bus_we_o, 0);
        chk("rst_sel", bus_sel_o, 0);
        chk("rst_adr", bus_adr_o, 0);
        chk("rst_dat", bus_dat_o, 0);
        chk("rst_stallreq", stallreq, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_adel", adel, 0);
        chk("rst_ades", ades, 0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Ack while MEM/WB frozen: data parks in HOLD until stall[4] drops
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h500; mem_size = SZ_WORD; mem_sext = 1'b0;
        sb.push_back('{32'hCAFE_F00D, 4'b1111});
        tick();
        stall = 6'b010000;
        bus_ack_i = 1'b1; bus_dat_i = 32'hCAFE_F00D;
        #1;
        chk("hold_ack_rdata", mem_rdata, sb[0].rdata);
        tick();
        bus_ack_i = 1'b0; bus_dat_i = 32'h0; mem_req = 1'b0;
        #1;
        chk("hold_rdata1", mem_rdata, sb[0].rdata);
        chk("hold_stallreq", stallreq, 0);
        chk("hold_cyc", bus_cyc_o, 0);
        tick();
        chk("hold_rdata2", mem_rdata, sb.pop_front().rdata);
        stall = 6'b000000;
        tick();
        chk("hold_exit_rdata", mem_rdata, 0);

        // Flush in BUSY: bus cycle completes, data dropped, no HOLD
        mem_req = 1'b1; mem_addr = 32'h600;
        tick();
        flush = 1'b1;
        #1;
        chk("flush_stallreq", stallreq, 0);
        tick();
        flush = 1'b0; mem_req = 1'b0;
        #1;
        chk("flush_cyc_kept", bus_cyc_o, 1);
        chk("flush_stallreq2", stallreq, 0);
        stall = 6'b010000;
        bus_ack_i = 1'b1; bus_dat_i = 32'h1234_5678;
        #1;
        chk("flush_ack_rdata", mem_rdata, 0);
        chk("flush_ack_stallreq", stallreq, 0);
        tick();
        bus_ack_i = 1'b0;
        #1;
        chk("flush_end_cyc", bus_cyc_o, 0);
        chk("flush_end_rdata", mem_rdata, 0);
        stall = 6'b000000;
        tick();

        // Reset in the middle of a bus cycle abandons it
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h700; mem_wdata = 32'h55AA_55AA;
        tick();
        chk("rb_cyc", bus_cyc_o, 1);
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rb_cyc0", bus_cyc_o, 0);
        chk("rb_stb0", bus_stb_o, 0);
        chk("rb_we0", bus_we_o, 0);
        chk("rb_dat0", bus_dat_o, 0);
        chk("rb_adr0", bus_adr_o, 0);
        chk("rb_stallreq", stallreq, 0);
        tick();

        // mem_req held through completion with EX frozen: no second access
        stall = 6'b001000;
        mem_req = 1'b1; mem_addr = 32'h800; mem_size = SZ_WORD;
        #1;
        chk("held_req_stallreq", stallreq, 1);
        tick(); tick();
        bus_ack_i = 1'b1; bus_dat_i = 32'h0000_0077;
        #1;
        chk("held_ack_rdata", mem_rdata, 32'h77);
        tick();
        bus_ack_i = 1'b0;
        #1;
        chk("held_no_restart", stallreq, 0);
        tick();
        chk("held_no_cyc", bus_cyc_o, 0);
        chk("held_no_restart2", stallreq, 0);
        stall = 6'b000000;
        #1;
        chk("held_not_armed", stallreq, 0);
        tick();
        chk("held_rearmed", stallreq, 1);
        tick();
        chk("held_new_cyc", bus_cyc_o, 1);
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0; mem_req = 1'b0;
        #1;
        chk("held_new_done", bus_cyc_o, 0);
        tick();

`ifdef DMEM_ADDR_CHECK_EN
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h102; mem_size = SZ_WORD;
        #1;
        chk("adel", adel, 1);
        chk("adel_ades", ades, 0);
        chk("adel_stallreq", stallreq, 0);
        tick();
        chk("adel_no_cyc", bus_cyc_o, 0);
        mem_we = 1'b1; mem_addr = 32'h201; mem_size = SZ_HALF;
        #1;
        chk("ades", ades, 1);
        chk("ades_adel", adel, 0);
        tick();
        chk("ades_no_cyc", bus_cyc_o, 0);
        mem_req = 1'b0;
        tick();
`else
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h102; mem_size = SZ_WORD;
        #1;
        chk("noerr_adel", adel, 0);
        chk("noerr_ades", ades, 0);
        mem_req = 1'b0;
        #1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bus_if.md
DMEM_BUS_IF -- requirements
Module: dmem_bus_if

Interface
REQ-001 SHALL have a clock `clk` and reset `rst`; one clock; reset is synchronous and active-high.
REQ-002 Ports, in order `name  direction  width  meaning`:
- clk  in  1  clock, rising edge.
- rst  in  1  sync active-high reset.
- stall  in  6  pipeline stall vector; stall[4] high = downstream (MEM/WB) frozen.
- flush  in  1  exception flush; abort the pending access.
- mem_req  in  1  MEM stage load/store request, level.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data, right-justified.
- mem_size  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as word.
- mem_sext  in  1  sign-extend loaded byte/half.
- mem_rdata  out  32  aligned, extended load result.
- stallreq  out  1  request to freeze pipeline.
- bus_adr_o  out  32  bus address, word aligned ([1:0]=00).
- bus_dat_o  out  32  bus write data.
- bus_sel_o  out  4  byte lane enables.
- bus_we_o  out  1  bus write.
- bus_cyc_o  out  1  bus cycle.
- bus_stb_o  out  1  bus strobe.
- bus_dat_i  in  32  bus read data.
- bus_ack_i  in  1  bus acknowledge.
- adel  out  1  load address error (macro only).
- ades  out  1  store address error (macro only).

Function
REQ-003 SHALL implement FSM states IDLE, BUSY, HOLD.
REQ-004 IDLE: mem_req & !flush & !addr_err SHALL cause bus_cyc_o/bus_stb_o = 1 on the next edge, state -> BUSY; stallreq SHALL be high combinationally in the request cycle.
REQ-005 BUSY: stallreq SHALL be 1 until bus_ack_i; cyc/stb/adr/sel/we/dat SHALL be held stable until ack.
REQ-006 BUSY with bus_ack_i: stallreq SHALL be 0 in the ack cycle; mem_rdata SHALL present the extended bus_dat_i combinationally; cyc/stb SHALL be 0 next edge; the read data SHALL be captured into a hold buffer; next state = HOLD if stall[4]=1, else IDLE.
REQ-007 HOLD: mem_rdata SHALL drive the hold buffer; stallreq SHALL be 0; state -> IDLE when stall[4]=0.
REQ-008 Byte lanes SHALL be big-endian:
- byte: addr[1:0] 00/01/10/11 -> sel 1000/0100/0010/0001.
- half: addr[1] 0/1 -> 1100/0011.
- word: 1111.
REQ-009 Store data SHALL be replicated across lanes: byte {4{b}}, half {2{h}}.
REQ-010 Load data SHALL be extracted from the selected lane and zero- or sign-extended to 32 bits per mem_sext.
REQ-011 flush in BUSY SHALL NOT drop cyc/stb before ack; on ack the data SHALL be discarded and state -> IDLE; stallreq SHALL be 0 from the flush cycle on.
REQ-012 flush in HOLD SHALL cause state -> IDLE next edge.
REQ-013 Outside an access, mem_rdata SHALL be 0.
REQ-014 mem_req held through its own completion SHALL NOT start a second access; a new access starts only from IDLE on a cycle with stall[3]=0 preceding.

Reset
REQ-015 rst SHALL set state IDLE and set cyc, stb, we, sel, adr, dat_o, the hold buffer, stallreq, adel and ades to 0 on the next edge, including mid-BUSY (bus cycle abandoned).

Configuration
REQ-016 Macro DMEM_ADDR_CHECK_EN defined: misaligned half (addr[0]=1) or word (addr[1:0]!=00) SHALL assert adel (load) or ades (store) combinationally, suppress the bus access and keep stallreq 0.
REQ-017 Macro DMEM_ADDR_CHECK_EN undefined: adel = ades = 0; misaligned addresses SHALL be truncated to the natural alignment.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding, the size codes (SZ_BYTE/SZ_HALF/SZ_WORD) and the stall-bit index constants.
REQ-019 Lane select and load extract/extend SHALL be one combinational sub-module, dmem_lane_align.

Verification
REQ-020 The bench SHALL cover the following scenarios:
- Word load at 0x100, bus_dat_i=0x11223344, ack after 3 cycles -> stallreq high 4 cycles, mem_rdata=0x11223344, sel=1111.
- Byte load at 0x103, sext=1, bus_dat_i=0x000000F0 -> sel=0001, mem_rdata=0xFFFFFFF0; with sext=0 -> 0x000000F0.
- Half store 0xBEEF at 0x202 -> sel=0011, bus_dat_o=0xBEEFBEEF, we=1.
- Ack while stall[4]=1 for 2 cycles -> HOLD, mem_rdata stable at captured value, IDLE after stall[4] falls.
- flush in BUSY then ack -> no data kept, stallreq=0, IDLE; rst mid-BUSY -> cyc=stb=0 next edge.
- With the macro: word load at 0x102 -> adel=1, no cyc.
